// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline datapath.
//   DATA_W / REG_AW : datapath width and register-file address width
//   ld_size_e       : load-size encoding driven by the MEM stage
//   sext8 / sext16  : extension helpers used by the load aligner
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        LD_WORD = 2'b00,
        LD_HALF = 2'b01,
        LD_BYTE = 2'b10,
        LD_RSVD = 2'b11    // reserved, handled as a word load
    } ld_size_e;

    // Extend a byte to 32 bits; zero-extend when uns is set.
    function automatic logic [31:0] sext8(input logic [7:0] v, input logic uns);
        logic signed [31:0] s;
        s = 32'(signed'(v));
        return uns ? {24'h0, v} : s;
    endfunction

    // Extend a halfword to 32 bits; zero-extend when uns is set.
    function automatic logic [31:0] sext16(input logic [15:0] v, input logic uns);
        logic signed [31:0] s;
        s = 32'(signed'(v));
        return uns ? {16'h0, v} : s;
    endfunction

endpackage

// File: rtl/load_align.sv
// ----------------------------------------------------------------------------
// load_align
// Combinational big-endian load aligner for the MEM/WB boundary.
// Ports:
//   Rdata       in  32  word returned by data memory
//   off         in  2   byte offset within the word (ALUres[1:0])
//   ld_size     in  2   00 word, 01 half, 10 byte, 11 word
//   ld_unsigned in  1   zero-extend sub-word loads
//   ld_data     out 32  aligned, extended load value
//   misalign    out 1   access not naturally aligned for its size
// ----------------------------------------------------------------------------
module load_align (
    input  logic [31:0] Rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    output logic [31:0] ld_data,
    output logic        misalign
);
    import mips_pkg::*;

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane 0 is the most significant byte (big-endian).
    always_comb begin
        byte_lane = Rdata[31:24];
        case (off)
            2'd0: byte_lane = Rdata[31:24];
            2'd1: byte_lane = Rdata[23:16];
            2'd2: byte_lane = Rdata[15:8];
            2'd3: byte_lane = Rdata[7:0];
            default: byte_lane = Rdata[31:24];
        endcase
    end

    // Only off[1] selects the halfword; off[0]=1 is flagged as misaligned.
    assign half_lane = off[1] ? Rdata[15:0] : Rdata[31:16];

    always_comb begin
        ld_data  = Rdata;
        misalign = 1'b0;
        case (ld_size)
            LD_BYTE: ld_data = sext8(byte_lane, ld_unsigned);
            LD_HALF: begin
                ld_data  = sext16(half_lane, ld_unsigned);
                misalign = off[0];
            end
            default: begin
                ld_data  = Rdata;
                misalign = (off != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// ----------------------------------------------------------------------------
// mem_wb_stage
// MEM/WB pipeline boundary: aligns load data, selects the writeback value,
// holds the MEM/WB register (stall/flush aware) and counts retirements.
// Ports:
//   clk, rst (sync, active-low), stall, flush : control
//   valid_in, ALUres, Rdata, RegWrite_in, MemtoReg_in, link_in, pc8_in,
//   wreg_in, ld_size, ld_unsigned             : MEM-stage inputs
//   wb_valid, RegWrite_out, wreg_out, wdata_out, misalign, instret
//                                             : registered WB-stage outputs
// ----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] ALUres,
    input  logic [DATA_W-1:0] Rdata,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic              link_in,
    input  logic [DATA_W-1:0] pc8_in,
    input  logic [REG_AW-1:0] wreg_in,
    input  logic [1:0]        ld_size,
    input  logic              ld_unsigned,
    output logic              wb_valid,
    output logic              RegWrite_out,
    output logic [REG_AW-1:0] wreg_out,
    output logic [DATA_W-1:0] wdata_out,
    output logic              misalign,
    output logic [31:0]       instret
);
    import mips_pkg::*;

    logic [31:0]       ld_data;
    logic              la_misalign;

    logic              misalign_d;
    logic              we_d;
    logic [DATA_W-1:0] wdata_d;
    logic              retire_d;

    logic              wb_valid_q;
    logic              we_q;
    logic [REG_AW-1:0] wreg_q;
    logic [DATA_W-1:0] wdata_q;
    logic              misalign_q;
    logic [31:0]       instret_q;

    load_align u_load_align (
        .Rdata       (Rdata),
        .off         (ALUres[1:0]),
        .ld_size     (ld_size),
        .ld_unsigned (ld_unsigned),
        .ld_data     (ld_data),
        .misalign    (la_misalign)
    );

    // Alignment only matters when the value actually comes from memory.
    assign misalign_d = MemtoReg_in & la_misalign;

    // Writes to $0 are suppressed here so the register file never sees them.
    assign we_d = valid_in & RegWrite_in & ~misalign_d & (wreg_in != '0);

    assign retire_d = valid_in & ~misalign_d;

    always_comb begin
        wdata_d = ALUres;
        if (link_in) begin
            wdata_d = pc8_in;
        end else if (MemtoReg_in) begin
            wdata_d = ld_data;
        end
    end

    // MEM -> WB register boundary
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_valid_q <= 1'b0;
            we_q       <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
            instret_q  <= '0;
        end else if (flush) begin
            // Bubble: the retirement count is deliberately left alone.
            wb_valid_q <= 1'b0;
            we_q       <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
        end else if (!stall) begin
            wb_valid_q <= valid_in;
            we_q       <= we_d;
            wreg_q     <= wreg_in;
            wdata_q    <= wdata_d;
            misalign_q <= misalign_d;
            if (retire_d) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign wb_valid     = wb_valid_q;
    assign RegWrite_out = we_q;
    assign wreg_out     = wreg_q;
    assign wdata_out    = wdata_q;
    assign misalign     = misalign_q;
    assign instret      = instret_q;

endmodule
